// File: rtl/program_loader.sv
// program_loader: byte-stream loader that fills instruction memory while holding the CPU.
// Stream format: LEN, then N pairs of {HI opcode byte, LO literal byte}, then an 8-bit checksum.
module program_loader #(
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [14:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [7:0]    count
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, ERR} state_t;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state_q, state_d;
  logic [7:0] len_q, len_d, acc_q, acc_d, count_q, count_d;
  logic [6:0] op_q, op_d;
  logic [AW-1:0] widx_q, widx_d, addr_q, addr_d;
  logic [14:0] wdata_q, wdata_d;
  logic we_q, we_d, done_q, done_d, error_q, error_d, take;
  assign rx_ready = state_q inside {LEN, HI, LO, CSUM};
  assign take = rx_ready && rx_valid;
  assign cpu_hold = state_q != IDLE;
  assign im_we = we_q;
  assign im_addr = addr_q;
  assign im_wdata = wdata_q;
  assign done = done_q;
  assign error = error_q;
  assign count = count_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    acc_d = acc_q;
    count_d = count_q;
    op_d = op_q;
    widx_d = widx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    done_d = 1'b0;
    error_d = error_q;
    case (state_q)
      IDLE, ERR: if (start) begin
        state_d = LEN;
        count_d = '0;
        error_d = 1'b0;
        acc_d = '0;
        widx_d = '0;
      end
      LEN: if (take) begin
        acc_d = acc_q + rx_data;
        len_d = rx_data;
        state_d = (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_W) ? ERR : HI;
      end
      HI: if (take) begin
        acc_d = acc_q + rx_data;
        op_d = rx_data[6:0];
        state_d = rx_data[7] ? ERR : LO;
      end
      LO: if (take) begin
        acc_d = acc_q + rx_data;
        we_d = 1'b1;
        addr_d = widx_q;
        wdata_d = {op_q, rx_data};
        widx_d = widx_q == LAST ? widx_q : widx_q + AW'(1);
        count_d = count_q + 8'd1;
        state_d = count_q + 8'd1 < len_q ? HI : CSUM;
      end
      CSUM: if (take) begin
        done_d = rx_data == acc_q;
        state_d = rx_data == acc_q ? IDLE : ERR;
      end
      default: state_d = IDLE;
    endcase
    // entering ERR from any state latches the sticky flag; leaving via start clears it above
    if (state_d == ERR) error_d = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      op_q <= '0;
      widx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      acc_q <= acc_d;
      count_q <= count_d;
      op_q <= op_d;
      widx_q <= widx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
endmodule
